// File: rtl/uart_baud_acq_gen.sv
// Baud / acquisition strobe generator for the UART receive path.
// AcqSig_o marks in-bit sampling points, BaudSig_o marks bit boundaries.
module uart_baud_acq_gen #(
  parameter int               DIV_W   = 16,
  parameter logic [DIV_W-1:0] MIN_DIV = 16'd3,
  parameter logic [3:0]       MIN_ACQ = 4'd3,
  parameter logic [DIV_W-1:0] DEF_DIV = 16'd26,
  parameter logic [3:0]       DEF_ACQ = 4'd8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             p_Enable_i,
  input  logic [DIV_W-1:0] BaudDiv_i,
  input  logic [3:0]       AcqNumPerBit_i,
  input  logic             p_Resync_i,
  output logic             AcqSig_o,
  output logic             BaudSig_o,
  output logic [3:0]       AcqCnt_o,
  output logic             p_CfgError_o
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]       state;
  logic [DIV_W-1:0] div_sh;
  logic [3:0]       acq_sh;
  logic [DIV_W-1:0] div_cnt;
  logic [3:0]       acq_cnt;

  logic             div_low;
  logic             acq_low;
  logic [DIV_W-1:0] div_cl;
  logic [3:0]       acq_cl;
  logic             run;
  logic             tick;
  logic             wrap;
  logic             load;
  logic [3:0]       acq_nxt;

  always_comb begin
    div_low = (BaudDiv_i < MIN_DIV);
    acq_low = (AcqNumPerBit_i < MIN_ACQ);
    div_cl  = div_low ? MIN_DIV : BaudDiv_i;
    acq_cl  = acq_low ? MIN_ACQ : AcqNumPerBit_i;
    // The IDLE->RUN edge only arms the counters; counting starts next clk.
    run     = p_Enable_i && (state == RUN);
    tick    = run && !p_Resync_i && (div_cnt == div_sh);
    wrap    = tick && (acq_cnt == acq_sh - 4'd1);
    acq_nxt = wrap ? 4'd0 : acq_cnt + 4'd1;
    // While running, the rate is only re-latched on a bit boundary.
    load    = !p_Enable_i || wrap;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= p_Enable_i ? RUN : IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_sh       <= DEF_DIV;
      acq_sh       <= DEF_ACQ;
      p_CfgError_o <= 1'b0;
    end else begin
      if (load) begin
        div_sh <= div_cl;
        acq_sh <= acq_cl;
      end
      if (!p_Enable_i)                   p_CfgError_o <= div_low || acq_low;
      else if (wrap && (div_low || acq_low)) p_CfgError_o <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt   <= '0;
      acq_cnt   <= 4'd0;
      AcqSig_o  <= 1'b0;
      BaudSig_o <= 1'b0;
      AcqCnt_o  <= 4'd0;
    end else if (!run || p_Resync_i) begin
      // Resync wins over a coincident tick, which is dropped.
      div_cnt   <= '0;
      acq_cnt   <= 4'd0;
      AcqSig_o  <= 1'b0;
      BaudSig_o <= 1'b0;
      AcqCnt_o  <= 4'd0;
    end else if (tick) begin
      div_cnt   <= '0;
      acq_cnt   <= acq_nxt;
      AcqSig_o  <= 1'b1;
      BaudSig_o <= wrap;
      AcqCnt_o  <= acq_nxt;
    end else begin
      div_cnt   <= div_cnt + 1'b1;
      AcqSig_o  <= 1'b0;
      BaudSig_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_baud_acq_gen.sv
// Bench for uart_baud_acq_gen: countdown-style reference model checked every
// cycle, plus directed literal interval checks.
module tb_uart_baud_acq_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        p_Enable_i;
  logic [15:0] BaudDiv_i;
  logic [3:0]  AcqNumPerBit_i;
  logic        p_Resync_i;
  logic        AcqSig_o;
  logic        BaudSig_o;
  logic [3:0]  AcqCnt_o;
  logic        p_CfgError_o;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  uart_baud_acq_gen dut (
    .clk(clk), .rst(rst), .p_Enable_i(p_Enable_i), .BaudDiv_i(BaudDiv_i),
    .AcqNumPerBit_i(AcqNumPerBit_i), .p_Resync_i(p_Resync_i),
    .AcqSig_o(AcqSig_o), .BaudSig_o(BaudSig_o), .AcqCnt_o(AcqCnt_o),
    .p_CfgError_o(p_CfgError_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d want %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: time remaining to the next sampling point, and the
  // position within the bit as a modulo counter of ticks.
  bit running = 0;
  int left = 0, idx = 0, m_div = 26, m_acq = 8;
  bit m_err = 0, e_acq = 0, e_baud = 0;
  int e_cnt = 0;

  function automatic int clamp3(input int v);
    return (v < 3) ? 3 : v;
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        running = 0; left = 0; idx = 0; m_div = 26; m_acq = 8;
        m_err = 0; e_acq = 0; e_baud = 0; e_cnt = 0;
      end else begin
        automatic bit illegal = (BaudDiv_i < 3) || (AcqNumPerBit_i < 3);
        e_acq = 0; e_baud = 0;
        if (!p_Enable_i) begin
          running = 0; idx = 0; e_cnt = 0;
          m_div = clamp3(BaudDiv_i); m_acq = clamp3(AcqNumPerBit_i);
          m_err = illegal;
        end else if (!running || p_Resync_i) begin
          running = 1; left = m_div + 1; idx = 0; e_cnt = 0;
        end else begin
          left--;
          if (left == 0) begin
            e_acq = 1;
            idx = (idx + 1) % m_acq;
            e_cnt = idx;
            if (idx == 0) begin
              e_baud = 1;
              m_div = clamp3(BaudDiv_i); m_acq = clamp3(AcqNumPerBit_i);
              if (illegal) m_err = 1;
            end
            left = m_div + 1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("acq_sig",   AcqSig_o,     e_acq);
      chk("baud_sig",  BaudSig_o,    e_baud);
      chk("acq_cnt",   AcqCnt_o,     e_cnt);
      chk("cfg_error", p_CfgError_o, m_err);
    end
  end

  // Clocks from the current negedge until the negedge that shows AcqSig_o.
  task automatic wait_acq(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!AcqSig_o && n < 500);
    if (!AcqSig_o) n = -1;
  endtask

  initial begin
    int n;
    rst = 1'b0;
    p_Enable_i = 1'b1; BaudDiv_i = 16'd9; AcqNumPerBit_i = 4'd8; p_Resync_i = 1'b0;
    #1 chk_on = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_acq", AcqSig_o, 0);
    chk("rst_cnt", AcqCnt_o, 0);

    // Enabled at release: defaults 26/8 stay in the shadow for the first bit.
    rst = 1'b1;
    wait_acq(n); chk("def_first", n, 28);
    wait_acq(n); chk("def_period", n, 27);

    // Nominal 9/8.
    p_Enable_i = 1'b0;
    repeat (2) @(negedge clk);
    p_Enable_i = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      wait_acq(n);
      chk("nom_period", n, (i == 1) ? 11 : 10);
      chk("nom_cnt", AcqCnt_o, i % 8);
      chk("nom_baud", BaudSig_o, (i == 8) ? 1 : 0);
    end

    // Mid-bit rate change takes effect only after the bit boundary.
    for (int i = 1; i <= 8; i++) begin
      if (i == 4) BaudDiv_i = 16'd19;
      wait_acq(n); chk("chg_old", n, 10);
    end
    chk("chg_baud", BaudSig_o, 1);
    wait_acq(n); chk("chg_new", n, 20);

    // Resync at div_cnt=5, acq_cnt=3.
    BaudDiv_i = 16'd9; p_Enable_i = 1'b0;
    repeat (2) @(negedge clk);
    p_Enable_i = 1'b1;
    repeat (3) wait_acq(n);
    chk("rs_pre_cnt", AcqCnt_o, 3);
    repeat (5) @(negedge clk);
    p_Resync_i = 1'b1;
    @(negedge clk);
    p_Resync_i = 1'b0;
    chk("rs_quiet", AcqSig_o, 0);
    wait_acq(n); chk("rs_period", n, 10);
    chk("rs_cnt", AcqCnt_o, 1);

    // Resync colliding with div_cnt==div_sh.
    repeat (9) @(negedge clk);
    p_Resync_i = 1'b1;
    @(negedge clk);
    p_Resync_i = 1'b0;
    chk("col_quiet", AcqSig_o, 0);
    chk("col_cnt0", AcqCnt_o, 0);
    wait_acq(n); chk("col_period", n, 10);
    chk("col_cnt", AcqCnt_o, 1);

    // Clamp of illegal values.
    p_Enable_i = 1'b0; BaudDiv_i = 16'd1; AcqNumPerBit_i = 4'd2;
    repeat (2) @(negedge clk);
    chk("clamp_err", p_CfgError_o, 1);
    p_Enable_i = 1'b1;
    wait_acq(n); chk("clamp_first", n, 5);
    wait_acq(n); chk("clamp_period", n, 4);
    wait_acq(n); chk("clamp_baud", BaudSig_o, 1);
    p_Enable_i = 1'b0; BaudDiv_i = 16'd9; AcqNumPerBit_i = 4'd8;
    @(negedge clk);
    chk("err_clear", p_CfgError_o, 0);
    BaudDiv_i = 16'd0;
    @(negedge clk);
    chk("err_set", p_CfgError_o, 1);
    BaudDiv_i = 16'd9; p_Enable_i = 1'b1;
    repeat (10) wait_acq(n);
    chk("err_sticky", p_CfgError_o, 1);

    // Asynchronous reset mid-run.
    #2 rst = 1'b0;
    #1;
    chk("arst_err", p_CfgError_o, 0);
    chk("arst_acq", AcqSig_o, 0);
    chk("arst_baud", BaudSig_o, 0);
    chk("arst_cnt", AcqCnt_o, 0);
    repeat (2) @(negedge clk);
    p_Enable_i = 1'b0;
    rst = 1'b1;

    // Random traffic against the model.
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      p_Enable_i = ($urandom_range(0, 299) != 0) ? 1'b1 : (c % 3 == 0 ? 1'b0 : p_Enable_i);
      if ($urandom_range(0, 60) == 0) BaudDiv_i = 16'($urandom_range(0, 14));
      if ($urandom_range(0, 60) == 0) AcqNumPerBit_i = 4'($urandom_range(0, 11));
      p_Resync_i = ($urandom_range(0, 40) == 0);
    end
    p_Resync_i = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
